// File: rtl/frame_packetizer.sv
// TX framer: prepends preamble/sync/mode/length/CRC-8 header to a payload symbol
// stream, pads or drains on length mismatch, then holds an idle gap between frames.
module frame_packetizer #(
  parameter int          BYTES     = 1,
  parameter int          PRE_LEN   = 256,
  parameter int          SYNC_LEN  = 32,
  parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
  parameter int          LEN_W     = 16,
  parameter int          GAP_LEN   = 4,
  localparam int         BITS      = 8*BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [LEN_W-1:0] payload_length,
  input  logic [BITS-1:0]  I_tdata,
  input  logic             I_tvalid,
  output logic             I_tready,
  input  logic             I_tlast,
  input  logic             I_tuser,
  output logic [BITS-1:0]  O_tdata,
  output logic             O_tvalid,
  input  logic             O_tready,
  output logic             O_tlast,
  output logic             O_tuser,
  output logic             hdr_vld,
  output logic             pld_vld,
  output logic             busy,
  output logic             pkt_sent,
  output logic             err_short,
  output logic             err_long
);

  localparam int M_OFF = PRE_LEN + SYNC_LEN;
  localparam int L_OFF = M_OFF + 8;
  localparam int C_OFF = L_OFF + 16;
  localparam int HLEN  = C_OFF + 8;
  localparam int HW    = $clog2(HLEN);
  localparam int GW    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_BYPASS, S_HDR, S_PLD, S_PAD, S_DRAIN, S_GAP} state_t;

  state_t           state;
  logic [HW-1:0]    hcnt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] nsym;
  logic [15:0]      len16;
  logic [7:0]       crc_q;
  logic             is_bpsk;
  logic [GW-1:0]    gap_cnt;
  logic             gap_on;
  logic             hbit;
  int               hi;

  wire adv      = !O_tvalid || O_tready;
  wire in_acc   = I_tvalid && I_tready;
  wire pld_last = (cnt == nsym - LEN_W'(1));
  wire hdr_last = (hcnt == HW'(HLEN - 1));

  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 15; k >= 0; k--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[k]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  always_comb begin
    hi   = int'(hcnt);
    hbit = 1'b0;
    if (hi < PRE_LEN)    hbit = hcnt[0];
    else if (hi < M_OFF) hbit = SYNC_WORD[5'(31 - (hi - PRE_LEN))];
    else if (hi < L_OFF) hbit = hcnt[0] ^ is_bpsk;
    else if (hi < C_OFF) hbit = len16[4'(15 - (hi - L_OFF))];
    else                 hbit = crc_q[3'(7 - (hi - C_OFF))];
  end

  always_comb begin
    I_tready = 1'b0;
    case (state)
      S_BYPASS, S_PLD: I_tready = adv;
      S_DRAIN:         I_tready = 1'b1;
      default:         I_tready = 1'b0;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      cnt       <= '0;
      nsym      <= '0;
      len16     <= '0;
      crc_q     <= '0;
      is_bpsk   <= 1'b0;
      gap_cnt   <= '0;
      gap_on    <= 1'b0;
      O_tdata   <= '0;
      O_tvalid  <= 1'b0;
      O_tlast   <= 1'b0;
      O_tuser   <= 1'b1;
      hdr_vld   <= 1'b0;
      pld_vld   <= 1'b0;
      pkt_sent  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      pkt_sent  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      // output slot empties on acceptance unless a state below reloads it
      if (adv) begin
        O_tvalid <= 1'b0;
        O_tlast  <= 1'b0;
        hdr_vld  <= 1'b0;
        pld_vld  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          hcnt   <= '0;
          cnt    <= '0;
          gap_on <= 1'b0;
          if (!en) state <= S_BYPASS;
          else if (I_tvalid) begin
            is_bpsk <= I_tuser;
            nsym    <= I_tuser ? payload_length
                               : (payload_length >> 1) + LEN_W'(payload_length[0]);
            len16   <= 16'(payload_length);
            crc_q   <= crc8(16'(payload_length));
            state   <= S_HDR;
          end
        end
        S_BYPASS: if (in_acc) begin
          O_tvalid <= 1'b1;
          O_tdata  <= I_tdata;
          O_tuser  <= I_tuser;
          O_tlast  <= I_tlast;
          if (I_tlast) state <= S_IDLE;
        end
        S_HDR: if (adv) begin
          O_tvalid <= 1'b1;
          O_tdata  <= {BITS{hbit}};
          O_tuser  <= 1'b1;
          hdr_vld  <= 1'b1;
          O_tlast  <= hdr_last && (nsym == '0);
          hcnt     <= hcnt + HW'(1);
          if (hdr_last) state <= (nsym != '0) ? S_PLD : S_GAP;
        end
        S_PLD: if (in_acc) begin
          O_tvalid <= 1'b1;
          O_tdata  <= I_tdata;
          O_tuser  <= is_bpsk;
          pld_vld  <= 1'b1;
          O_tlast  <= pld_last;
          cnt      <= cnt + LEN_W'(1);
          if (pld_last) state <= I_tlast ? S_GAP : S_DRAIN;
          else if (I_tlast) begin
            err_short <= 1'b1;
            state     <= S_PAD;
          end
        end
        S_PAD: if (adv) begin
          O_tvalid <= 1'b1;
          O_tdata  <= '0;
          O_tuser  <= is_bpsk;
          pld_vld  <= 1'b1;
          O_tlast  <= pld_last;
          cnt      <= cnt + LEN_W'(1);
          if (pld_last) state <= S_GAP;
        end
        S_DRAIN: if (I_tvalid && I_tlast) begin
          err_long <= 1'b1;
          state    <= S_GAP;
        end
        S_GAP: begin
          // idle count starts only once the tlast beat has left the output slot
          if (!gap_on) begin
            if (adv) begin
              gap_on   <= 1'b1;
              pkt_sent <= 1'b1;
              gap_cnt  <= '0;
            end
          end else if (gap_cnt == GW'(GAP_LEN - 1)) begin
            gap_on <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packetizer.sv
// Scoreboard bench for frame_packetizer: expected beats queued at stimulus time,
// popped and compared at every accepted output beat.
module tb_frame_packetizer;
  localparam int          BITS     = 8;
  localparam int          PRE_LEN  = 256;
  localparam int          SYNC_LEN = 32;
  localparam logic [31:0] SYNC_WORD = 32'h1ACFFC1D;
  localparam int          LEN_W    = 16;
  localparam int          GAP_LEN  = 4;
  localparam int          HLEN     = PRE_LEN + SYNC_LEN + 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [LEN_W-1:0] payload_length = '0;
  logic [BITS-1:0]  I_tdata = '0;
  logic             I_tvalid = 1'b0;
  logic             I_tready;
  logic             I_tlast = 1'b0;
  logic             I_tuser = 1'b0;
  logic [BITS-1:0]  O_tdata;
  logic             O_tvalid;
  logic             O_tready = 1'b1;
  logic             O_tlast, O_tuser, hdr_vld, pld_vld, busy, pkt_sent, err_short, err_long;

  frame_packetizer #(
    .BYTES(1), .PRE_LEN(PRE_LEN), .SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD),
    .LEN_W(LEN_W), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .payload_length(payload_length),
    .I_tdata(I_tdata), .I_tvalid(I_tvalid), .I_tready(I_tready), .I_tlast(I_tlast),
    .I_tuser(I_tuser), .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tready(O_tready),
    .O_tlast(O_tlast), .O_tuser(O_tuser), .hdr_vld(hdr_vld), .pld_vld(pld_vld),
    .busy(busy), .pkt_sent(pkt_sent), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic last; logic user;} src_t;
  typedef logic [11:0] exp_t;  // {last, user, hdr, pld, data}

  src_t       src_q[$];
  exp_t       exp_q[$];
  logic [7:0] pay_d[$];
  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_beats = 0, n_pkt = 0, n_es = 0, n_el = 0, n_gap_bad = 0;
  int gap_cyc = 0, last_gap = -1;
  bit gap_run = 0, in_acc = 0, mon_en = 1, rdy_rand = 0, src_bub = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [15:0] v);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 1; b >= 0; b--) begin
      c = c ^ v[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic hdr_bit(input int i, input logic bpsk, input logic [15:0] l,
                                   input logic [7:0] c);
    logic [31:0] s; logic [15:0] lt; logic [7:0] ct;
    if (i < PRE_LEN) return (i % 2) == 1;
    if (i < PRE_LEN + SYNC_LEN) begin s = SYNC_WORD << (i - PRE_LEN); return s[31]; end
    if (i < PRE_LEN + SYNC_LEN + 8) return ((i % 2) == 1) ^ bpsk;
    if (i < PRE_LEN + SYNC_LEN + 24) begin
      lt = l << (i - PRE_LEN - SYNC_LEN - 8); return lt[15];
    end
    ct = c << (i - PRE_LEN - SYNC_LEN - 24);
    return ct[7];
  endfunction

  task automatic drive_src();
    src_t s;
    forever begin
      @(posedge clk); #1;
      if (in_acc) begin
        if (src_q.size() > 0) s = src_q.pop_front();
        I_tvalid = 1'b0;
        in_acc = 0;
      end
      if (!I_tvalid && src_q.size() > 0 && (!src_bub || $urandom_range(0, 1) == 1)) begin
        I_tvalid = 1'b1;
        I_tdata  = src_q[0].d;
        I_tlast  = src_q[0].last;
        I_tuser  = src_q[0].user;
      end
    end
  endtask

  task automatic drive_sink();
    forever begin
      @(posedge clk); #1;
      O_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      in_acc = I_tvalid && I_tready;
      if (in_acc) n_acc++;
      if (mon_en) begin
        if (O_tvalid && O_tready) begin
          n_beats++;
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat", {O_tlast, O_tuser, hdr_vld, pld_vld, O_tdata}, e);
          end
        end
        if (err_short) n_es++;
        if (err_long) n_el++;
        if (pkt_sent) begin n_pkt++; gap_run = 1; gap_cyc = 0; end
        if (gap_run) begin
          if (busy) begin
            gap_cyc++;
            if (O_tvalid) n_gap_bad++;
          end else begin
            gap_run = 0;
            last_gap = gap_cyc;
          end
        end
      end
    end
  endtask

  task automatic check_rst(input string tag);
    chk(tag, {O_tvalid, O_tlast, O_tuser, hdr_vld, pld_vld, busy, pkt_sent, err_short,
              err_long, I_tready, O_tdata},
        {1'b0, 1'b0, 1'b1, 7'b0, 8'h00});
  endtask

  task automatic start_frame(input int len, input logic bpsk, input int ndata, input int tl_idx,
                             input logic [7:0] dstart, input bit drop);
    int nsym, nreal, k;
    logic [15:0] l16; logic [7:0] c, d; logic b;
    n_pkt = 0; n_es = 0; n_el = 0; n_acc = 0; last_gap = -1;
    nsym  = bpsk ? len : (len + 1) / 2;
    nreal = (tl_idx + 1 < nsym) ? tl_idx + 1 : nsym;
    l16   = 16'(len);
    c     = crc_ref(l16);
    pay_d.delete();
    for (int i = 0; i < HLEN; i++) begin
      b = hdr_bit(i, bpsk, l16, c);
      exp_q.push_back({(i == HLEN - 1) && (nsym == 0), 1'b1, 1'b1, 1'b0, {8{b}}});
    end
    for (int i = 0; i < ndata; i++) pay_d.push_back(dstart + 8'(i));
    for (int i = 0; i < nsym; i++) begin
      d = (i < nreal) ? pay_d[i] : 8'h00;
      exp_q.push_back({i == nsym - 1, bpsk, 1'b0, 1'b1, d});
    end
    payload_length = LEN_W'(len);
    for (int i = 0; i < ndata; i++)
      src_q.push_back({pay_d[i], i == tl_idx, (i == 0) ? bpsk : 1'($urandom_range(0, 1))});
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    chk("frame_start", busy, 1);
    if (drop) begin src_q.delete(); I_tvalid = 1'b0; end
    payload_length = 16'hBEEF;
  endtask

  task automatic end_frame(input string tag, input int es, input int el, input int acc);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < 8000) begin @(negedge clk); k++; end
    chk({tag, "_done"}, (exp_q.size() == 0 && !busy), 1);
    @(negedge clk);
    chk({tag, "_pkt_sent"}, n_pkt, 1);
    chk({tag, "_err_short"}, n_es, es);
    chk({tag, "_err_long"}, n_el, el);
    chk({tag, "_gap"}, last_gap, GAP_LEN);
    chk({tag, "_consumed"}, n_acc, acc);
    chk({tag, "_src_left"}, src_q.size(), 0);
  endtask

  initial begin
    int k, b0;
    src_t s;
    fork drive_src(); drive_sink(); monitor(); join_none
    repeat (3) @(negedge clk);
    check_rst("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_frame(16, 1'b1, 16, 15, 8'h00, 0); end_frame("t1_bpsk16", 0, 0, 16);
    start_frame(5, 1'b0, 3, 2, 8'h40, 0);    end_frame("t2_qpsk5", 0, 0, 3);
    rdy_rand = 1; src_bub = 1;
    start_frame(16, 1'b1, 16, 15, 8'h00, 0); end_frame("t3_backpr", 0, 0, 16);
    rdy_rand = 0; src_bub = 0;
    start_frame(8, 1'b1, 5, 4, 8'hA0, 0);    end_frame("t4_short", 1, 0, 5);
    start_frame(2, 1'b1, 4, 3, 8'hC0, 0);    end_frame("t_long", 0, 1, 4);
    start_frame(7, 1'b0, 4, 3, 8'h11, 0);    end_frame("t_qpsk_odd", 0, 0, 4);
    start_frame(0, 1'b1, 1, 0, 8'h55, 1);    end_frame("t5_len0", 0, 0, 0);

    b0 = n_beats;
    start_frame(16, 1'b1, 16, 15, 8'h00, 0);
    k = 0;
    while (n_beats < b0 + 100 && k < 2000) begin @(negedge clk); k++; end
    chk("t6_reach_beat100", n_beats >= b0 + 100, 1);
    rst_n = 1'b0; mon_en = 0; exp_q.delete(); src_q.delete(); I_tvalid = 1'b0; in_acc = 0;
    @(negedge clk);
    check_rst("t6_mid_reset");
    rst_n = 1'b1; mon_en = 1; gap_run = 0;
    @(negedge clk);
    start_frame(16, 1'b1, 16, 15, 8'h20, 0); end_frame("t6_restart", 0, 0, 16);

    en = 1'b0; rdy_rand = 1; n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      s = {8'($urandom_range(0, 255)), i == 4, 1'($urandom_range(0, 1))};
      src_q.push_back(s);
      exp_q.push_back({s.last, s.user, 1'b0, 1'b0, s.d});
    end
    k = 0;
    while (exp_q.size() > 0 && k < 500) begin @(negedge clk); k++; end
    chk("bypass_done", exp_q.size(), 0);
    chk("bypass_consumed", n_acc, 5);
    chk("gap_valid_beats", n_gap_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
